cabac_byte_feeder: RTL and testbench

- Bitstream byte source for the VVC arithmetic decoder.
- Sits directly downstream of the bits-needed logic: consumes its `request_byte` pulse and returns the next slice-data byte for the value-register refill.
- Also performs range-decoder init: fetches the first three bytes into a 24-bit initial value.
- Buffers incoming bytes in a small FIFO behind a valid/ready input handshake.

---
 rtl/cabac_pkg.sv | 15 +
 rtl/cabac_byte_fifo.sv | 62 ++++++
 rtl/cabac_byte_feeder.sv | 156 +++++++++++++++
 tb/tb_cabac_byte_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC bitstream byte feeder.
package cabac_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN
   } feeder_state_e;

   localparam int    INIT_BYTES = 3;
   localparam byte_t EPB_BYTE   = 8'h03;

endpackage

// File: rtl/cabac_byte_fifo.sv
// Small power-of-two byte FIFO with synchronous flush; head is visible on dout
// combinationally whenever the FIFO is non-empty.
module cabac_byte_fifo
   import cabac_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  byte_t         din,
   input  logic          pop,
   output byte_t         dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   byte_t           mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; only the pointers and level define validity.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/cabac_byte_feeder.sv
// Byte source for the VVC arithmetic decoder: range-decoder init and per-request
// byte delivery. Optional emulation-prevention stripping via CABAC_EPB_STRIP_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; request_byte is an error
// INIT  | popping the first three bytes into init_value, MSB first
// RUN   | serving request_byte, one byte per request, stall if empty
module cabac_byte_feeder
   import cabac_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [7:0]    bs_data,
   input  logic          bs_valid,
   output logic          bs_ready,
   input  logic          request_byte,
   output logic [7:0]    byte_out,
   output logic          byte_valid,
   output logic [23:0]   init_value,
   output logic          init_done,
   output logic          stall,
   output logic [AW:0]   level,
   output logic          err
);

   feeder_state_e state;
   logic [1:0]    init_cnt;
   logic          pending;
   logic          fifo_full;
   logic          fifo_empty;
   byte_t         head;
   logic          accept;
   logic          push;
   logic          pop;
   logic          flush;

   assign bs_ready = !fifo_full;
   assign accept   = bs_valid && bs_ready;
   assign flush    = start && (state != IDLE);

`ifdef CABAC_EPB_STRIP_EN
   logic [1:0] zero_run;
   logic       strip;

   // An 0x03 after two zero bytes is an emulation-prevention byte: accepted, not stored.
   assign strip = (zero_run >= 2'd2) && (bs_data == EPB_BYTE);
   assign push  = accept && !strip && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_run <= 2'd0;
      end else if (start) begin
         zero_run <= 2'd0;
      end else if (accept) begin
         if (strip)                   zero_run <= 2'd0;
         else if (bs_data == 8'h00)   zero_run <= (zero_run == 2'd2) ? 2'd2 : zero_run + 2'd1;
         else                         zero_run <= 2'd0;
      end
   end
`else
   assign push = accept && !flush;
`endif

   always_comb begin
      pop = 1'b0;
      if (!start) begin
         case (state)
            INIT:    pop = !fifo_empty;
            RUN:     pop = !fifo_empty && (pending || request_byte);
            default: pop = 1'b0;
         endcase
      end
   end

   cabac_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .din   (bs_data),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         init_cnt   <= 2'd0;
         init_value <= 24'h0;
         init_done  <= 1'b0;
         byte_out   <= 8'h00;
         byte_valid <= 1'b0;
         stall      <= 1'b0;
         pending    <= 1'b0;
         err        <= 1'b0;
      end else begin
         init_done  <= 1'b0;
         byte_valid <= 1'b0;
         if (start) begin
            state    <= INIT;
            init_cnt <= 2'd0;
            pending  <= 1'b0;
            stall    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (request_byte) err <= 1'b1;
               end
               INIT: begin
                  if (request_byte) err <= 1'b1;
                  if (pop) begin
                     init_value <= {init_value[15:0], head};
                     if (init_cnt == 2'(INIT_BYTES - 1)) begin
                        init_cnt  <= 2'd0;
                        init_done <= 1'b1;
                        state     <= RUN;
                     end else begin
                        init_cnt <= init_cnt + 2'd1;
                     end
                  end
               end
               RUN: begin
                  if (pending) begin
                     // Only one outstanding request is tracked; extras are flagged and dropped.
                     if (request_byte) err <= 1'b1;
                     if (pop) begin
                        byte_out   <= head;
                        byte_valid <= 1'b1;
                        pending    <= 1'b0;
                        stall      <= 1'b0;
                     end
                  end else if (request_byte) begin
                     if (pop) begin
                        byte_out   <= head;
                        byte_valid <= 1'b1;
                     end else begin
                        pending <= 1'b1;
                        stall   <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Directed self-checking bench for cabac_byte_feeder (DEPTH=4); expectations
// follow CABAC_EPB_STRIP_EN when it is defined.
module tb_cabac_byte_feeder;
   import cabac_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    bs_data = 8'h00;
   logic          bs_valid = 1'b0;
   logic          bs_ready;
   logic          request_byte = 1'b0;
   logic [7:0]    byte_out;
   logic          byte_valid;
   logic [23:0]   init_value;
   logic          init_done;
   logic          stall;
   logic [AW:0]   level;
   logic          err;

   int total = 0;
   int bad   = 0;

   cabac_byte_feeder #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bs_data      (bs_data),
      .bs_valid     (bs_valid),
      .bs_ready     (bs_ready),
      .request_byte (request_byte),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .init_value   (init_value),
      .init_done    (init_done),
      .stall        (stall),
      .level        (level),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic        v;
      logic [7:0]  d;
      logic        r;
      logic        ebv;
      logic [7:0]  ebo;
      logic        eid;
      logic        est;
      logic [2:0]  elv;
      logic        eer;
      logic        civ;
      logic [23:0] eiv;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic r,
                               input logic ebv, input logic [7:0] ebo, input logic eid, input logic est,
                               input logic [2:0] elv, input logic eer, input logic civ, input logic [23:0] eiv);
      vec_t t;
      t.s = s; t.v = v; t.d = d; t.r = r;
      t.ebv = ebv; t.ebo = ebo; t.eid = eid; t.est = est;
      t.elv = elv; t.eer = eer; t.civ = civ; t.eiv = eiv;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] obs();
      return {byte_valid, byte_out, init_done, stall, level, err, bs_ready};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_t epb_in [4];
      bit    seen;

      //           s  v  d      r   bv bo     id st lv er civ iv
      vq.push_back(mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 1, 24'h000000));
      vq.push_back(mk(0, 1, 8'hA1, 0,  0, 8'h00, 0, 0, 1, 0, 0, 24'h000000));
      vq.push_back(mk(0, 1, 8'hB2, 0,  0, 8'h00, 0, 0, 1, 0, 1, 24'h0000A1));
      vq.push_back(mk(0, 1, 8'hC3, 0,  0, 8'h00, 0, 0, 1, 0, 1, 24'h00A1B2));
      vq.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 0, 0, 1, 24'hA1B2C3));
      vq.push_back(mk(0, 1, 8'h11, 0,  0, 8'h00, 0, 0, 1, 0, 1, 24'hA1B2C3));
      vq.push_back(mk(0, 1, 8'h22, 0,  0, 8'h00, 0, 0, 2, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  1, 8'h11, 0, 0, 1, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 0,  0, 8'h11, 0, 0, 1, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  1, 8'h22, 0, 0, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  0, 8'h22, 0, 1, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 0,  0, 8'h22, 0, 1, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 0,  0, 8'h22, 0, 1, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h5A, 0,  0, 8'h22, 0, 1, 1, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 0,  1, 8'h5A, 0, 0, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h01, 0,  0, 8'h5A, 0, 0, 1, 0, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h02, 0,  0, 8'h5A, 0, 0, 2, 0, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h04, 0,  0, 8'h5A, 0, 0, 3, 0, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h05, 0,  0, 8'h5A, 0, 0, 4, 0, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h06, 0,  0, 8'h5A, 0, 0, 4, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  1, 8'h01, 0, 0, 3, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  1, 8'h02, 0, 0, 2, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  1, 8'h04, 0, 0, 1, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  1, 8'h05, 0, 0, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  0, 8'h05, 0, 1, 0, 0, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 1,  0, 8'h05, 0, 1, 0, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'hAA, 0,  0, 8'h05, 0, 1, 1, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'hBB, 0,  1, 8'hAA, 0, 0, 1, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'hCC, 0,  0, 8'hAA, 0, 0, 2, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'hDD, 0,  0, 8'hAA, 0, 0, 3, 1, 0, 24'h0));
      vq.push_back(mk(1, 1, 8'hEE, 0,  0, 8'hAA, 0, 0, 0, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h10, 0,  0, 8'hAA, 0, 0, 1, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h20, 0,  0, 8'hAA, 0, 0, 1, 1, 0, 24'h0));
      vq.push_back(mk(0, 1, 8'h30, 0,  0, 8'hAA, 0, 0, 1, 1, 0, 24'h0));
      vq.push_back(mk(0, 0, 8'h00, 0,  0, 8'hAA, 1, 0, 0, 1, 1, 24'h102030));
      vq.push_back(mk(0, 0, 8'h00, 0,  0, 8'hAA, 0, 0, 0, 1, 0, 24'h0));

      #12 rst_n = 1'b1;
      check("reset_outputs", 64'(obs()), 64'({1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1}));
      check("reset_init_value", 64'(init_value), 64'h0);

      for (int i = 0; i < vq.size(); i++) begin
         start        = vq[i].s;
         bs_valid     = vq[i].v;
         bs_data      = vq[i].d;
         request_byte = vq[i].r;
         tick();
         check($sformatf("vec%0d", i), 64'(obs()),
               64'({vq[i].ebv, vq[i].ebo, vq[i].eid, vq[i].est, vq[i].elv, vq[i].eer, (vq[i].elv != 3'd4)}));
         if (vq[i].civ) check($sformatf("vec%0d_init_value", i), 64'(init_value), 64'(vq[i].eiv));
      end
      start = 1'b0; bs_valid = 1'b0; request_byte = 1'b0; bs_data = 8'h00;

      // Asynchronous reset between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 64'(obs()), 64'({1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1}));
      check("async_reset_init_value", 64'(init_value), 64'h0);
      #2 rst_n = 1'b1;
      tick();

      request_byte = 1'b1;
      tick();
      request_byte = 1'b0;
      check("idle_request_err", 64'({byte_valid, err}), 64'({1'b0, 1'b1}));

      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      check("reset_clears_err", 64'(err), 64'(0));

      epb_in[0] = 8'h00; epb_in[1] = 8'h00; epb_in[2] = 8'h03; epb_in[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         bs_valid = 1'b1;
         bs_data  = epb_in[i];
         tick();
      end
      bs_valid = 1'b0;
`ifdef CABAC_EPB_STRIP_EN
      check("epb_level", 64'(level), 64'(3));
`else
      check("epb_level", 64'(level), 64'(4));
`endif

      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         tick();
         if (init_done) seen = 1'b1;
      end
      check("epb_init_done_seen", 64'(seen), 64'(1));
`ifdef CABAC_EPB_STRIP_EN
      check("epb_init_value", 64'(init_value), 64'h000001);
      check("epb_level_after_init", 64'(level), 64'(0));
      request_byte = 1'b1;
      tick();
      request_byte = 1'b0;
      check("epb_request_empty", 64'({byte_valid, stall}), 64'({1'b0, 1'b1}));
`else
      check("epb_init_value", 64'(init_value), 64'h000003);
      check("epb_level_after_init", 64'(level), 64'(1));
      request_byte = 1'b1;
      tick();
      request_byte = 1'b0;
      check("epb_request_byte", 64'({byte_valid, byte_out, stall}), 64'({1'b1, 8'h01, 1'b0}));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
